dmem_rmw_ctrl: RTL
==================

# dmem_rmw_ctrl

Sequential data-memory access controller between the MEM-stage load/store formatting and a synchronous single-port 32-bit data RAM with one-cycle read latency. It runs each load as a read-and-extract and each sub-word store (SH/SB) as a read-modify-write, so the RAM needs no byte enables. A request/response handshake lets the pipeline stall while an access is in flight.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.
- `DEPTH_W`, 10: RAM word-address width; `mem_addr = addr[DEPTH_W+1:2]`.

Ports:
- `clk`  in  1  single clock.
- `rstn`  in  1  reset, **asynchronous, active-low**.
- `req_valid`  in  1  access request.
- `req_ready`  out  1  controller idle; request accepted when `req_valid & req_ready`.
- `req_addr`  in  ADDR_W  byte address.
- `req_access`  in  4  access code: LW=0, LH=1, LB=2, LHU=3, LBU=4, SW=5, SH=6, SB=7; codes 8–15 are invalid.
- `req_wdata`  in  32  store data, taken from the low bits.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load result; 0 for stores and errors.
- `resp_err`  out  1  misaligned access or invalid code; valid with `resp_valid`.
- `mem_addr`  out  DEPTH_W  RAM word address.
- `mem_re`  out  1  RAM read strobe.
- `mem_we`  out  1  RAM write strobe.
- `mem_wdata`  out  32  RAM write word.
- `mem_rdata`  in  32  RAM read data, valid the cycle after `mem_re`.

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE:
  - `req_ready=1`.
  - On accept, latch addr, access and wdata.
  - Next state:
    - Error (misaligned or invalid code) → DONE.
    - SW → WRITE.
    - All other codes → READ.
- Misaligned: LW/SW with `addr[1:0]≠0`; LH/LHU/SH with `addr[0]=1`. Byte accesses are never misaligned. Errors perform no RAM access.
- READ: `mem_re=1`. Next state WAIT.
- WAIT: register `mem_rdata` into `rd_word`.
  - Load → DONE.
  - SH/SB → WRITE.
- WRITE: `mem_we=1`.
  - SW: `mem_wdata = wdata`.
  - SH: `mem_wdata` replaces halfword `addr[1]` of `rd_word` with `wdata[15:0]`.
  - SB: `mem_wdata` replaces byte `addr[1:0]` of `rd_word` with `wdata[7:0]`.
  - Next state DONE.
- DONE: `resp_valid=1`.
  - `resp_rdata` is extracted from `rd_word`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
  - Next state IDLE.
- `mem_addr` comes from the latched address in every non-IDLE state and is 0 in IDLE.
- `mem_re` and `mem_we` are never high in the same cycle.
- `req_valid` in any non-IDLE state is ignored, because `req_ready=0`.

## Timing
- Accept at cycle T0. `resp_valid` at:
  - Error: T1.
  - SW: T2, with write at T1.
  - Loads: T3, with read at T1 and sample at T2.
  - SH/SB: T4, with read at T1 and write at T3.
- Back-to-back: the next request is accepted in the cycle after DONE, at the earliest.
- Outputs are Moore (state plus registers only). No combinational path from `req_*` to any output.
- Reset values:
  - State IDLE, so `req_ready=1`.
  - `resp_valid`, `resp_err`, `mem_re` and `mem_we` are 0.
  - `resp_rdata`, `mem_addr` and `mem_wdata` are 0.
  - All internal registers are 0.
- Reset mid-operation: outputs take their reset values immediately (asynchronous). An RMW interrupted before WRITE leaves RAM untouched. No response is issued for the aborted request.

## Structure
- Shared package `dmem_pkg`: the 4-bit access-code constants (also used by the formatting logic upstream) and the state encoding.
- One sub-module `dmem_lane_fmt`: purely combinational byte/halfword extract and merge (inputs `rd_word`, `wdata`, `addr[1:0]`, access; outputs `load_val`, `merged`). The FSM and registers stay in `dmem_rmw_ctrl`.

## Test plan
- **LB sign extension:** RAM[0]=0x8034_12F0; LB addr 0x3 → `resp_valid` at T3, `resp_rdata=0xFFFF_FF80`, `resp_err=0`. LBU addr 0x3 → `resp_rdata=0x0000_0080`.
- **SB read-modify-write:** RAM[1]=0x1122_3344; SB addr 0x5, wdata 0xAB → read at T1, `mem_we` at T3, `mem_wdata=0x1122_AB44`; follow-up LW addr 0x4 returns 0x1122_AB44.
- **SH upper half:** SH addr 0x6, wdata 0xDEAD_BEEF on RAM[1]=0 → RAM[1]=0xBEEF_0000, `resp_valid` at T4. LH addr 0x6 → `resp_rdata=0xFFFF_BEEF`.
- **Misaligned and invalid:** LW addr 0x2, SH addr 0x1, and code 9 → each gives `resp_valid` and `resp_err=1` at T1, with `mem_re`/`mem_we` never asserted.
- **SW fast path and back-to-back:** SW addr 0x8, wdata 0xCAFE_F00D with `req_valid` held high → write at T1, DONE at T2, next request accepted at T3; `req_valid` during busy cycles is ignored.
- **Reset mid-RMW:** assert `rstn=0` in WAIT of an SB → all outputs go to 0 immediately with `req_ready=1`, there is no write, and RAM is unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared access codes, FSM state encoding and access classification helpers
//
// Purpose: definitions shared by the data-memory controller and the upstream
// load/store formatting logic.
//   ACC_*        4-bit access codes (8..15 are invalid)
//   state_e      controller FSM state encoding
//   acc_invalid  high for codes outside LW..SB
//   acc_misalign high when the access is not naturally aligned to its size
//   acc_is_load  high for LW/LH/LB/LHU/LBU

package dmem_pkg;

  localparam logic [3:0] ACC_LW  = 4'd0;
  localparam logic [3:0] ACC_LH  = 4'd1;
  localparam logic [3:0] ACC_LB  = 4'd2;
  localparam logic [3:0] ACC_LHU = 4'd3;
  localparam logic [3:0] ACC_LBU = 4'd4;
  localparam logic [3:0] ACC_SW  = 4'd5;
  localparam logic [3:0] ACC_SH  = 4'd6;
  localparam logic [3:0] ACC_SB  = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Every valid code has bit 3 clear.
  function automatic logic acc_invalid(input logic [3:0] acc);
    return acc[3];
  endfunction

  // Byte accesses can never be misaligned.
  function automatic logic acc_misalign(input logic [3:0] acc, input logic [1:0] addr_lo);
    logic mis;
    case (acc)
      ACC_LW, ACC_SW:          mis = (addr_lo != 2'b00);
      ACC_LH, ACC_LHU, ACC_SH: mis = addr_lo[0];
      default:                 mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic acc_is_load(input logic [3:0] acc);
    return (acc == ACC_LW) || (acc == ACC_LH) || (acc == ACC_LB) ||
           (acc == ACC_LHU) || (acc == ACC_LBU);
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// rtl/dmem_lane_fmt.sv - combinational byte/halfword extract and merge for the data RAM
//
// Purpose: selects the addressed lane of a RAM word for loads (with sign or
// zero extension) and builds the write word for stores.
// Ports:
//   rd_word   in  32  word read back from RAM
//   wdata     in  32  store data (low bits used for SH/SB)
//   addr_lo   in  2   byte offset within the word
//   access    in  4   access code
//   load_val  out 32  extended load result, 0 for non-load codes
//   merged    out 32  word to write: wdata for SW, rd_word with one lane replaced for SH/SB

module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [3:0]  access,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo)
      2'd0: byte_sel = rd_word[7:0];
      2'd1: byte_sel = rd_word[15:8];
      2'd2: byte_sel = rd_word[23:16];
      2'd3: byte_sel = rd_word[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    load_val = 32'h0;
    case (access)
      ACC_LW:  load_val = rd_word;
      ACC_LH:  load_val = {{16{half_sel[15]}}, half_sel};
      ACC_LB:  load_val = {{24{byte_sel[7]}}, byte_sel};
      ACC_LHU: load_val = {16'h0, half_sel};
      ACC_LBU: load_val = {24'h0, byte_sel};
      default: load_val = 32'h0;
    endcase
  end

  always_comb begin
    merged = rd_word;
    case (access)
      ACC_SW: merged = wdata;
      ACC_SH: begin
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      ACC_SB: begin
        case (addr_lo)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          2'd3: merged[31:24] = wdata[7:0];
          default: merged = rd_word;
        endcase
      end
      default: merged = rd_word;
    endcase
  end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// rtl/dmem_rmw_ctrl.sv - sequential load / read-modify-write controller for a single-port data RAM
//
// Purpose: runs loads as read-and-extract and SH/SB as read-modify-write so the
// RAM needs no byte enables. One access in flight at a time.
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only while idle)
//   req_addr/req_access/req_wdata  byte address, access code, store data
//   resp_valid/resp_rdata/resp_err one-cycle completion with load result or error
//   mem_addr/mem_re/mem_we/mem_wdata/mem_rdata  RAM port, read data one cycle after mem_re

module dmem_rmw_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DEPTH_W = 10
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [3:0]         req_access,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  output logic [DEPTH_W-1:0] mem_addr,
  output logic               mem_re,
  output logic               mem_we,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  localparam int LA_W = DEPTH_W + 2;

  state_e            state_q, state_d;
  logic [LA_W-1:0]   addr_q, addr_d;
  logic [3:0]        access_q, access_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rd_word_q, rd_word_d;
  logic              err_q, err_d;

  logic              accept;
  logic              req_err;
  logic [31:0]       load_val;
  logic [31:0]       merged;

  // Address bits above the RAM depth do not select anything.
  logic addr_hi_unused;
  assign addr_hi_unused = ^req_addr[ADDR_W-1:LA_W];

  assign accept  = req_valid && (state_q == ST_IDLE);
  assign req_err = acc_invalid(req_access) || acc_misalign(req_access, req_addr[1:0]);

  dmem_lane_fmt u_lane_fmt (
    .rd_word  (rd_word_q),
    .wdata    (wdata_q),
    .addr_lo  (addr_q[1:0]),
    .access   (access_q),
    .load_val (load_val),
    .merged   (merged)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      access_q  <= 4'h0;
      wdata_q   <= 32'h0;
      rd_word_q <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      access_q  <= access_d;
      wdata_q   <= wdata_d;
      rd_word_q <= rd_word_d;
      err_q     <= err_d;
    end
  end

  // Next state and register updates.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    access_d  = access_q;
    wdata_d   = wdata_q;
    rd_word_d = rd_word_q;
    err_d     = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d   = req_addr[LA_W-1:0];
          access_d = req_access;
          wdata_d  = req_wdata;
          err_d    = req_err;
          if (req_err)                   state_d = ST_DONE;
          else if (req_access == ACC_SW) state_d = ST_WRITE;
          else                           state_d = ST_READ;
        end
      end
      ST_READ: state_d = ST_WAIT;
      ST_WAIT: begin
        rd_word_d = mem_rdata;
        state_d   = acc_is_load(access_q) ? ST_DONE : ST_WRITE;
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Moore outputs: derived only from state and registers.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_DONE);
    resp_err   = (state_q == ST_DONE) && err_q;
    resp_rdata = ((state_q == ST_DONE) && !err_q) ? load_val : 32'h0;
    mem_addr   = (state_q == ST_IDLE) ? '0 : addr_q[LA_W-1:2];
    mem_re     = (state_q == ST_READ);
    mem_we     = (state_q == ST_WRITE);
    mem_wdata  = (state_q == ST_WRITE) ? merged : 32'h0;
  end

endmodule
